wire4_fanout: RTL and testbench
===============================

Name: wire4_fanout

Overview:
- Fixed 3-input / 4-output signal router: w=a, x=b, y=b, z=c.
- Input b is duplicated onto two outputs; a and c pass straight through.
- Used as a glue block where one control bit must drive two downstream consumers.
- Default build is purely combinational. An optional registered build and a per-output transition counter use the clock and reset.

Parameters:
- REGISTER_OUTPUTS, 0, 0 = outputs are combinational copies of the inputs (zero latency); 1 = outputs registered on clk (1-cycle latency).
- CNT_W, 16, width of each per-output transition counter.

Ports:
- clk  input  1  system clock; used by the registered mode and the counters.
- rst  input  1  asynchronous active-high reset.
- a  input  1  source for w.
- b  input  1  source for x and y.
- c  input  1  source for z.
- w  output  1  copy of a.
- x  output  1  copy of b.
- y  output  1  copy of b.
- z  output  1  copy of c.
- tog_w, tog_x, tog_y, tog_z  output  CNT_W each  count of rising-or-falling transitions seen on the corresponding output.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- REGISTER_OUTPUTS=0:
  - w=a, x=b, y=b, z=c, continuously.
  - No clock dependency; outputs update in the same timestep as the inputs.
  - rst has no effect on w/x/y/z.
  - Outputs must follow inputs that change on both clock edges.
- REGISTER_OUTPUTS=1:
  - On posedge clk: w<=a, x<=b, y<=b, z<=c.
  - rst asserted forces w=x=y=z=0 immediately, independent of clk.
  - First capture happens on the first posedge after rst deasserts.
- x and y are always bit-identical in both modes; any divergence is a bug.
- Counters:
  - A previous-value register per output, sampled on posedge clk.
  - The counter increments by 1 when the current output differs from the previous sample.
  - Counters saturate at all-ones and do not wrap.
  - rst clears all counters and previous-value registers to 0 asynchronously.
  - Changes faster than posedge sampling count at most once per clock.
- No X propagation: with known inputs, all outputs must be known (0/1) at all times after reset.
- Simultaneous reset and clock edge: reset wins.

Decomposition:
- Shared package: CNT_W default constant; an output-index enum (W, X, Y, Z) for counter arrays.
- One natural sub-module, wire4_toggle_counter: 1-bit input, saturating CNT_W counter with async reset. Instantiate it four times.
- Routing stays in the top module.

Test Plan:
- Exhaustive combinational, REGISTER_OUTPUTS=0: apply all 8 {a,b,c} values.
  - {a,b,c}=3'b101 -> {w,x,y,z}=4'b1001.
  - 3'b010 -> 4'b0110.
  - 3'b111 -> 4'b1111.
  - 3'b000 -> 4'b0000.
  - Check immediately, with no clock wait.
- Random stimulus changing on both clk edges for 200 half-cycles, mode 0 -> zero mismatches against w=a, x=y=b, z=c on every edge.
- Registered mode (REGISTER_OUTPUTS=1):
  - Hold rst=1, drive {a,b,c}=3'b111 -> outputs 0.
  - Deassert rst; at the next posedge -> outputs 4'b1111.
  - Change the inputs to 3'b000 mid-cycle -> outputs stay 4'b1111 until the next posedge.
- Async reset mid-operation, mode 1: outputs at 4'b1111, pulse rst between edges -> outputs go to 0 without a clock edge; tog_* counters read 0.
- Toggle counters: toggle b every cycle for 10 cycles, hold a=c=0 -> tog_x=tog_y=10, tog_w=tog_z=0.
- Counter saturation: with CNT_W=4, toggle b for 20 cycles -> tog_x=15 and holds at 15.

Source files
------------

// File: rtl/wire4_fanout_pkg.sv
// Shared definitions for the wire4_fanout router: counter width default,
// output indexing and the fixed a/b/c -> w/x/y/z routing function.
package wire4_fanout_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int NUM_OUTS      = 4;

  typedef enum logic [1:0] {
    OUT_W = 2'd0,
    OUT_X = 2'd1,
    OUT_Y = 2'd2,
    OUT_Z = 2'd3
  } out_idx_e;

  // b feeds both X and Y from the same source bit so they can never diverge
  function automatic logic [NUM_OUTS-1:0] route(input logic a, input logic b, input logic c);
    logic [NUM_OUTS-1:0] r;
    r        = '0;
    r[OUT_W] = a;
    r[OUT_X] = b;
    r[OUT_Y] = b;
    r[OUT_Z] = c;
    return r;
  endfunction

endpackage

// File: rtl/wire4_fanout_if.sv
// Signal bundle between the driver of a/b/c and the wire4_fanout router.
// master drives the sources; slave (the router) drives copies and counters.
interface wire4_fanout_if
  import wire4_fanout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             a;
  logic             b;
  logic             c;
  logic             w;
  logic             x;
  logic             y;
  logic             z;
  logic [CNT_W-1:0] tog_w;
  logic [CNT_W-1:0] tog_x;
  logic [CNT_W-1:0] tog_y;
  logic [CNT_W-1:0] tog_z;

  modport master (
    output a, b, c,
    input  w, x, y, z,
    input  tog_w, tog_x, tog_y, tog_z
  );

  modport slave (
    input  a, b, c,
    output w, x, y, z,
    output tog_w, tog_x, tog_y, tog_z
  );

endinterface

// File: rtl/wire4_toggle_counter.sv
// Saturating transition counter for one bit: compares the signal against its
// value at the previous posedge and counts differences, stopping at all-ones.
module wire4_toggle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             changed;
  logic             saturated;

  assign changed   = (sig_i != prev_q);
  assign saturated = (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (changed && !saturated) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sampling only at posedge means glitches between edges count at most once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= sig_i;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wire4_fanout.sv
// Fixed 3-in/4-out router (w=a, x=y=b, z=c) with optional output register
// and a saturating transition counter on each output.
module wire4_fanout
  import wire4_fanout_pkg::*;
#(
  parameter bit REGISTER_OUTPUTS = 1'b0,
  parameter int CNT_W            = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  wire4_fanout_if.slave  bus
);

  logic [NUM_OUTS-1:0] out_d;
  logic [NUM_OUTS-1:0] out_s;
  logic [CNT_W-1:0]    cnt [NUM_OUTS];

  assign out_d = route(bus.a, bus.b, bus.c);

  generate
    if (REGISTER_OUTPUTS) begin : g_reg
      logic [NUM_OUTS-1:0] out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign out_s = out_q;
    end else begin : g_comb
      assign out_s = out_d;
    end
  endgenerate

  assign bus.w = out_s[OUT_W];
  assign bus.x = out_s[OUT_X];
  assign bus.y = out_s[OUT_Y];
  assign bus.z = out_s[OUT_Z];

  // Counters observe the final outputs, so in registered mode they lag a cycle
  generate
    for (genvar i = 0; i < NUM_OUTS; i++) begin : g_cnt
      wire4_toggle_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .sig_i (out_s[i]),
        .cnt_o (cnt[i])
      );
    end
  endgenerate

  assign bus.tog_w = cnt[OUT_W];
  assign bus.tog_x = cnt[OUT_X];
  assign bus.tog_y = cnt[OUT_Y];
  assign bus.tog_z = cnt[OUT_Z];

endmodule

// File: tb/tb_wire4_fanout.sv
// Directed bench for wire4_fanout: combinational, registered and narrow-counter
// builds share one clock and reset.
module tb_wire4_fanout;

  logic clk;
  logic rst;
  int   nTests;
  int   nFails;

  wire4_fanout_if #(.CNT_W(16)) if0 ();
  wire4_fanout_if #(.CNT_W(16)) if1 ();
  wire4_fanout_if #(.CNT_W(4))  if2 ();

  wire4_fanout #(.REGISTER_OUTPUTS(1'b0), .CNT_W(16)) dutComb (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  wire4_fanout #(.REGISTER_OUTPUTS(1'b1), .CNT_W(16)) dutReg (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  wire4_fanout #(.REGISTER_OUTPUTS(1'b0), .CNT_W(4)) dutSat (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] outs;
    rst = 1'b1;
    if0.a = 1'b0; if0.b = 1'b0; if0.c = 1'b0;
    if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b1;
    if2.a = 1'b0; if2.b = 1'b0; if2.c = 1'b0;
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reset_reg_outs got %b expected 0000", outs);
    end
    nTests++;
    if (if0.tog_x !== 16'd0 || if1.tog_w !== 16'd0 || if2.tog_x !== 4'd0) begin
      nFails++;
      $display("[TB] FAIL reset_counters got %0d/%0d/%0d expected 0/0/0", if0.tog_x, if1.tog_w, if2.tog_x);
    end
  endtask

  task automatic test_comb_exhaustive();
    logic [3:0] expTab [8];
    logic [2:0] v;
    logic [3:0] outs;
    expTab[0] = 4'b0000; expTab[1] = 4'b0001; expTab[2] = 4'b0110; expTab[3] = 4'b0111;
    expTab[4] = 4'b1000; expTab[5] = 4'b1001; expTab[6] = 4'b1110; expTab[7] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {if0.a, if0.b, if0.c} = v;
      #1;
      outs = {if0.w, if0.x, if0.y, if0.z};
      nTests++;
      if (outs !== expTab[i]) begin
        nFails++;
        $display("[TB] FAIL comb_%b got %b expected %b", v, outs, expTab[i]);
      end
    end
  endtask

  task automatic test_both_edges();
    logic [2:0] v;
    logic [3:0] outs;
    logic [3:0] expOut;
    int         misses;
    misses = 0;
    for (int i = 0; i < 200; i++) begin
      @(clk);
      v = 3'($urandom_range(0, 7));
      {if0.a, if0.b, if0.c} = v;
      #1;
      outs   = {if0.w, if0.x, if0.y, if0.z};
      expOut = {v[2], v[1], v[1], v[0]};
      if (outs !== expOut) begin
        misses++;
        if (misses <= 5) $display("[TB] FAIL edge_follow_%0d got %b expected %b", i, outs, expOut);
      end
    end
    nTests++;
    if (misses != 0) begin
      nFails++;
      $display("[TB] FAIL edge_follow_total got %0d misses expected 0", misses);
    end
  endtask

  task automatic test_registered();
    logic [3:0] outs;
    rst = 1'b1;
    {if1.a, if1.b, if1.c} = 3'b111;
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reg_held_in_reset got %b expected 0000", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reg_before_first_edge got %b expected 0000", outs);
    end
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b1111) begin
      nFails++;
      $display("[TB] FAIL reg_first_capture got %b expected 1111", outs);
    end
    #2;
    {if1.a, if1.b, if1.c} = 3'b000;
    #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b1111) begin
      nFails++;
      $display("[TB] FAIL reg_mid_cycle_hold got %b expected 1111", outs);
    end
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reg_next_capture got %b expected 0000", outs);
    end
    {if1.a, if1.b, if1.c} = 3'b010;
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0110) begin
      nFails++;
      $display("[TB] FAIL reg_fanout_b got %b expected 0110", outs);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] outs;
    {if1.a, if1.b, if1.c} = 3'b111;
    @(posedge clk); #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b1111) begin
      nFails++;
      $display("[TB] FAIL async_pre_state got %b expected 1111", outs);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    outs = {if1.w, if1.x, if1.y, if1.z};
    nTests++;
    if (outs !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL async_outs got %b expected 0000", outs);
    end
    nTests++;
    if ({if1.tog_w, if1.tog_x, if1.tog_y, if1.tog_z} !== 64'd0) begin
      nFails++;
      $display("[TB] FAIL async_counters got %0d/%0d/%0d/%0d expected 0/0/0/0",
               if1.tog_w, if1.tog_x, if1.tog_y, if1.tog_z);
    end
    rst = 1'b0;
  endtask

  task automatic test_toggle_count();
    @(negedge clk);
    {if0.a, if0.b, if0.c} = 3'b000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if0.b = ~if0.b;
    end
    @(negedge clk); #1;
    nTests++;
    if (if0.tog_x !== 16'd10 || if0.tog_y !== 16'd10) begin
      nFails++;
      $display("[TB] FAIL toggle_xy got %0d/%0d expected 10/10", if0.tog_x, if0.tog_y);
    end
    nTests++;
    if (if0.tog_w !== 16'd0 || if0.tog_z !== 16'd0) begin
      nFails++;
      $display("[TB] FAIL toggle_wz got %0d/%0d expected 0/0", if0.tog_w, if0.tog_z);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    {if2.a, if2.b, if2.c} = 3'b000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if2.b = ~if2.b;
    end
    @(negedge clk); #1;
    nTests++;
    if (if2.tog_x !== 4'd15 || if2.tog_y !== 4'd15) begin
      nFails++;
      $display("[TB] FAIL sat_reach got %0d/%0d expected 15/15", if2.tog_x, if2.tog_y);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if2.b = ~if2.b;
    end
    @(negedge clk); #1;
    nTests++;
    if (if2.tog_x !== 4'd15) begin
      nFails++;
      $display("[TB] FAIL sat_hold got %0d expected 15", if2.tog_x);
    end
    nTests++;
    if (if2.tog_w !== 4'd0 || if2.tog_z !== 4'd0) begin
      nFails++;
      $display("[TB] FAIL sat_quiet got %0d/%0d expected 0/0", if2.tog_w, if2.tog_z);
    end
  endtask

  initial begin
    nTests = 0;
    nFails = 0;
    test_reset();
    rst = 1'b0;
    test_comb_exhaustive();
    test_both_edges();
    test_registered();
    test_async_reset();
    test_toggle_count();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
